// File: rtl/hyperram_target_if.sv
// hyperram_target_if: HyperBus target-side pad word bus plus 16-bit memory port
//  slave  = responder view (hyperram_target); master = pad/memory side view
//  csn, din[15:0], rwds_in[1:0]              captured bus inputs (din[15:8] = rising byte)
//  dout[15:0], oe_data, rwds_h, rwds_l, oe_rwds  bus outputs toward the DDR output cells
//  mem_addr, mem_re, mem_rdata, mem_we, mem_be, mem_wdata  word memory port
interface hyperram_target_if #(parameter int ADDR_W = 22);
   logic              csn;
   logic [15:0]       din;
   logic [1:0]        rwds_in;
   logic [15:0]       dout;
   logic              oe_data;
   logic              rwds_h;
   logic              rwds_l;
   logic              oe_rwds;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic [15:0]       mem_rdata;
   logic              mem_we;
   logic [1:0]        mem_be;
   logic [15:0]       mem_wdata;
   modport slave (
      input  csn, din, rwds_in, mem_rdata,
      output dout, oe_data, rwds_h, rwds_l, oe_rwds, mem_addr, mem_re, mem_we, mem_be, mem_wdata
   );
   modport master (
      output csn, din, rwds_in, mem_rdata,
      input  dout, oe_data, rwds_h, rwds_l, oe_rwds, mem_addr, mem_re, mem_we, mem_be, mem_wdata
   );
endinterface

// File: rtl/hyperram_target.sv
// hyperram_target: HyperBus memory-side responder streaming bursts to/from a 16-bit SRAM port
//  clk0   single rising-edge clock; rst_n asynchronous active-low reset
//  bus    hyperram_target_if.slave: captured DQ/RWDS words in, DQ/RWDS drive out, memory port
//  Fixed 2x initial latency; RWDS strobes read data and masks write bytes.
//  Optional HYPER_TGT_REGSPACE_EN: CR0/ID register space with CR0-selected latency;
//  without it, register-space commands are ignored until deselect.
module hyperram_target #(
   parameter int          ADDR_W     = 22,
   parameter int          LAT_CYCLES = 6,
   parameter int          WRAP_WORDS = 16,
   parameter logic [15:0] ID0_VALUE  = 16'h0C81
) (
   input logic              clk0,
   input logic              rst_n,
   hyperram_target_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CA1, CA2, LAT, RD, WR, IGN} state_t;
   localparam logic [ADDR_W-1:0] WMASK = ADDR_W'(WRAP_WORDS - 1);
   state_t            state, state_nx;
   logic [15:0]       ca_hi, ca_mid;
   logic [7:0]        cnt;
   logic [ADDR_W-1:0] addr, addr_inc, addr_nx, wr_addr;
   logic              wr_v;
   logic [15:0]       wr_data;
   logic [1:0]        wr_be;
   logic              reg_sp, rd_issue, wr_cap;
   logic [15:0]       reg_rd;
   int                lat_eff;
   assign reg_sp   = ca_hi[14];
   assign addr_inc = addr + 1'b1;
   // wrapped bursts only carry within the low log2(WRAP_WORDS) bits
   assign addr_nx  = ca_hi[13] ? addr_inc : (addr & ~WMASK) | (addr_inc & WMASK);
   // memory read is issued one cycle ahead of each output word, starting in the last latency cycle
   assign rd_issue = ca_hi[15] && !reg_sp && (state == RD || (state == LAT && cnt == 8'd1));
   assign wr_cap   = state == WR && !bus.csn;
`ifdef HYPER_TGT_REGSPACE_EN
   localparam bit REG_EN = 1'b1;
   localparam logic [ADDR_W-1:0] CR0_ADDR = ADDR_W'(12'h800);
   logic [15:0] cr0;
   always_ff @(posedge clk0 or negedge rst_n)
      if (!rst_n) cr0 <= 16'h8F1F;
      else if (wr_cap && reg_sp && addr == CR0_ADDR) cr0 <= bus.din;
   assign lat_eff = cr0[7:4] == 4'h0 ? 5 : cr0[7:4] == 4'h1 ? 6 : cr0[7:4] == 4'hE ? 3 :
                    cr0[7:4] == 4'hF ? 4 : LAT_CYCLES;
   assign reg_rd  = addr == CR0_ADDR ? cr0 : ID0_VALUE;
`else
   localparam bit REG_EN = 1'b0;
   assign lat_eff = LAT_CYCLES;
   assign reg_rd  = ID0_VALUE;
`endif
   always_ff @(posedge clk0 or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         ca_hi   <= '0;
         ca_mid  <= '0;
         cnt     <= '0;
         addr    <= '0;
         wr_v    <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_be   <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE) ca_hi <= bus.din;
         if (state == CA1) ca_mid <= bus.din;
         if (state == CA2) cnt <= 8'(2 * lat_eff - 1);
         else if (state == LAT) cnt <= cnt - 1'b1;
         if (state == CA2) addr <= ADDR_W'({ca_hi[12:0], ca_mid, bus.din[2:0]});
         else if (rd_issue || wr_cap) addr <= addr_nx;
         wr_v <= wr_cap && !reg_sp;
         if (wr_cap) begin
            wr_addr <= addr;
            wr_data <= bus.din;
            wr_be   <= ~bus.rwds_in;
         end
      end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = CA1;
         CA1:     state_nx = CA2;
         // register writes skip latency; register space without the feature is ignored
         CA2:     state_nx = !reg_sp ? LAT : !REG_EN ? IGN : ca_hi[15] ? LAT : WR;
         LAT:     state_nx = cnt == 8'd1 ? (ca_hi[15] ? RD : WR) : LAT;
         default: state_nx = state;
      endcase
      if (bus.csn) state_nx = IDLE;
   end
   assign bus.oe_data   = state == RD;
   assign bus.oe_rwds   = state inside {CA1, CA2, RD};
   assign bus.rwds_h    = state inside {CA1, CA2, RD};
   assign bus.rwds_l    = state inside {CA1, CA2};
   assign bus.dout      = state == RD ? (reg_sp ? reg_rd : bus.mem_rdata) : '0;
   assign bus.mem_re    = rd_issue;
   assign bus.mem_we    = wr_v;
   assign bus.mem_be    = wr_be;
   assign bus.mem_wdata = wr_data;
   assign bus.mem_addr  = wr_v ? wr_addr : addr;
endmodule
